// File: rtl/usb_link_pkg.sv
// Shared definitions for the USB link layer: PID codes, CRC5 constants and
// the token receive state encoding.
package usb_link_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_SOF   = 4'h5;

  localparam logic [4:0] CRC5_INIT     = 5'h1F;
  localparam logic [4:0] CRC5_RESIDUAL = 5'h0C;
  localparam logic [4:0] CRC5_POLY     = 5'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_B1,
    ST_B2,
    ST_DRAIN,
    ST_HOLD
  } rx_state_e;

  function automatic logic is_token_pid(input logic [3:0] pid);
    return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SETUP) || (pid == PID_SOF);
  endfunction

endpackage

// File: rtl/usb_crc5_chk.sv
// Combinational CRC5 residual check over a 16-bit token field
// (11 data bits + 5 CRC bits, shifted LSB-first).
module usb_crc5_chk
  import usb_link_pkg::*;
(
  input  logic [15:0] field_i,
  output logic        pass_o
);

  logic [4:0] crc;

  always_comb begin
    crc = CRC5_INIT;
    for (int i = 0; i < 16; i++) begin
      if (field_i[i] ^ crc[4]) crc = {crc[3:0], 1'b0} ^ CRC5_POLY;
      else                     crc = {crc[3:0], 1'b0};
    end
    pass_o = (crc == CRC5_RESIDUAL);
  end

endmodule

// File: rtl/usb_token_decoder.sv
// Receive-side token decoder: validates OUT/IN/SETUP/SOF packets from the PHY
// byte stream and presents decoded fields on a valid/ready port.
//
//   state    | meaning
//   ST_IDLE  | waiting for a sop byte (byte0 = PID)
//   ST_B1    | PID accepted, expecting byte1
//   ST_B2    | byte1 stored, expecting byte2 with eop
//   ST_DRAIN | discarding bytes of a rejected packet until eop
//   ST_HOLD  | token presented, waiting for tok_ready
module usb_token_decoder
  import usb_link_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter bit ADDR_FILTER = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       self_addr,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_sop,
  input  logic             rx_eop,
  output logic             rx_ready,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [3:0]       tok_pid,
  output logic [6:0]       tok_addr,
  output logic [3:0]       tok_endp,
  output logic [10:0]      tok_frame,
  output logic             crc5_err,
  output logic             pid_err,
  output logic             len_err,
  output logic [CNT_W-1:0] crc5_err_cnt
);

  rx_state_e   state_q;
  logic [3:0]  pid_q;
  logic [7:0]  byte1_q;

  logic        accept;
  logic [15:0] field;
  logic        crc_pass;
  logic        addr_drop;
  logic        b0_chk_ok;
  logic        b0_pid_err;
  logic        b0_len_err;
  rx_state_e   b0_state_d;

  assign rx_ready  = (state_q != ST_HOLD);
  assign accept    = rx_valid && rx_ready;
  assign field     = {rx_data, byte1_q};
  assign addr_drop = ADDR_FILTER && (pid_q != PID_SOF) && (field[6:0] != self_addr);

  usb_crc5_chk u_crc5_chk (
    .field_i (field),
    .pass_o  (crc_pass)
  );

  // Outcome of treating the current byte as byte0; shared by every state
  // because a sop always restarts decoding.
  always_comb begin
    b0_chk_ok  = (rx_data[7:4] == ~rx_data[3:0]);
    b0_pid_err = !b0_chk_ok;
    b0_len_err = 1'b0;
    b0_state_d = rx_eop ? ST_IDLE : ST_DRAIN;
    if (b0_chk_ok && is_token_pid(rx_data[3:0])) begin
      if (rx_eop) b0_len_err = 1'b1;
      else        b0_state_d = ST_B1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pid_q        <= '0;
      byte1_q      <= '0;
      tok_valid    <= 1'b0;
      tok_pid      <= '0;
      tok_addr     <= '0;
      tok_endp     <= '0;
      tok_frame    <= '0;
      crc5_err     <= 1'b0;
      pid_err      <= 1'b0;
      len_err      <= 1'b0;
      crc5_err_cnt <= '0;
    end else begin
      crc5_err <= 1'b0;
      pid_err  <= 1'b0;
      len_err  <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DRAIN: begin
          if (accept) begin
            if (rx_sop) begin
              state_q <= b0_state_d;
              pid_q   <= rx_data[3:0];
              pid_err <= b0_pid_err;
              len_err <= b0_len_err;
            end else if (rx_eop && state_q == ST_DRAIN) begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_B1, ST_B2: begin
          if (accept) begin
            if (rx_sop) begin
              // the truncated packet is reported, the new byte0 decoded at once
              state_q <= b0_state_d;
              pid_q   <= rx_data[3:0];
              pid_err <= b0_pid_err;
              len_err <= 1'b1;
            end else if (state_q == ST_B1) begin
              if (rx_eop) begin
                len_err <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                byte1_q <= rx_data;
                state_q <= ST_B2;
              end
            end else if (!rx_eop) begin
              len_err <= 1'b1;
              state_q <= ST_DRAIN;
            end else if (!crc_pass) begin
              crc5_err <= 1'b1;
              if (crc5_err_cnt != '1) crc5_err_cnt <= crc5_err_cnt + CNT_W'(1);
              state_q  <= ST_IDLE;
            end else if (addr_drop) begin
              state_q <= ST_IDLE;
            end else begin
              tok_valid <= 1'b1;
              tok_pid   <= pid_q;
              if (pid_q == PID_SOF) begin
                tok_addr  <= '0;
                tok_endp  <= '0;
                tok_frame <= field[10:0];
              end else begin
                tok_addr  <= field[6:0];
                tok_endp  <= field[10:7];
                tok_frame <= '0;
              end
              state_q <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (tok_ready) begin
            tok_valid <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_token_decoder.sv
// Randomized bench for usb_token_decoder: two instances (address filter on
// and off) share one byte stream and are scored against a packet-level model.
module tb_usb_token_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  self_addr;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_sop;
  logic        rx_eop;
  logic        tok_ready;

  logic        rx_ready_a, tok_valid_a, crc5_err_a, pid_err_a, len_err_a;
  logic [3:0]  tok_pid_a, tok_endp_a;
  logic [6:0]  tok_addr_a;
  logic [10:0] tok_frame_a;
  logic [7:0]  cnt_a;
  logic        rx_ready_b, tok_valid_b, crc5_err_b, pid_err_b, len_err_b;
  logic [3:0]  tok_pid_b, tok_endp_b;
  logic [6:0]  tok_addr_b;
  logic [10:0] tok_frame_b;
  logic [7:0]  cnt_b;

  always #5 clk = ~clk;

  usb_token_decoder #(.CNT_W(8), .ADDR_FILTER(1'b1)) dut_a (
    .clk(clk), .rst(rst), .self_addr(self_addr),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .rx_ready(rx_ready_a), .tok_valid(tok_valid_a), .tok_ready(tok_ready),
    .tok_pid(tok_pid_a), .tok_addr(tok_addr_a), .tok_endp(tok_endp_a), .tok_frame(tok_frame_a),
    .crc5_err(crc5_err_a), .pid_err(pid_err_a), .len_err(len_err_a), .crc5_err_cnt(cnt_a));

  usb_token_decoder #(.CNT_W(8), .ADDR_FILTER(1'b0)) dut_b (
    .clk(clk), .rst(rst), .self_addr(self_addr),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .rx_ready(rx_ready_b), .tok_valid(tok_valid_b), .tok_ready(tok_ready),
    .tok_pid(tok_pid_b), .tok_addr(tok_addr_b), .tok_endp(tok_endp_b), .tok_frame(tok_frame_b),
    .crc5_err(crc5_err_b), .pid_err(pid_err_b), .len_err(len_err_b), .crc5_err_cnt(cnt_b));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // pulse counters, sampled away from the active edge
  int n_crc_a = 0, n_pid_a = 0, n_len_a = 0;
  int n_crc_b = 0, n_pid_b = 0, n_len_b = 0;
  always @(negedge clk) begin
    if (crc5_err_a) n_crc_a++;
    if (pid_err_a)  n_pid_a++;
    if (len_err_a)  n_len_a++;
    if (crc5_err_b) n_crc_b++;
    if (pid_err_b)  n_pid_b++;
    if (len_err_b)  n_len_b++;
  end

  logic [7:0]  b_data[$];
  bit          b_sop[$];
  logic [3:0]  pids[4] = '{4'h1, 4'h9, 4'hD, 4'h5};

  int          m_cnt, m_crc, m_pid, m_len;
  bit          m_tok_a, m_tok_b;
  logic [3:0]  e_pid, e_endp;
  logic [6:0]  e_addr;
  logic [10:0] e_frame;

  // CRC field as a transmitter would append it: inverted remainder, MSB first on the wire
  function automatic logic [4:0] crc5_tx(input logic [10:0] d);
    logic [4:0] c;
    logic [4:0] r;
    logic       fb;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = d[i] ^ c[4];
      c  = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'h05;
    end
    for (int i = 0; i < 5; i++) r[i] = ~c[4-i];
    return r;
  endfunction

  function automatic bit is_tok(input logic [3:0] p);
    return (p == 4'h1) || (p == 4'h9) || (p == 4'hD) || (p == 4'h5);
  endfunction

  // Packet-level model: split the burst at sop bytes and judge each segment;
  // length errors are tracked by the byte on which they become visible.
  task automatic model_burst();
    int starts[$];
    bit lmark[64];
    int n;
    n = b_data.size();
    m_crc = 0; m_pid = 0; m_len = 0; m_tok_a = 0; m_tok_b = 0;
    for (int i = 0; i < 64; i++) lmark[i] = 0;
    for (int i = 0; i < n; i++) if (b_sop[i]) starts.push_back(i);
    for (int s = 0; s < starts.size(); s++) begin
      int st, en, len;
      bit last;
      logic [7:0]  b0;
      logic [15:0] f;
      st   = starts[s];
      en   = (s + 1 < starts.size()) ? starts[s+1] : n;
      len  = en - st;
      last = (en == n);
      b0   = b_data[st];
      if (b0[7:4] != ~b0[3:0]) m_pid++;
      else if (is_tok(b0[3:0])) begin
        if (len == 3 && last) begin
          f = {b_data[st+2], b_data[st+1]};
          if (f[15:11] != crc5_tx(f[10:0])) m_crc++;
          else begin
            m_tok_b = 1;
            m_tok_a = (b0[3:0] == 4'h5) || (f[6:0] == self_addr);
            e_pid   = b0[3:0];
            e_addr  = (b0[3:0] == 4'h5) ? 7'd0 : f[6:0];
            e_endp  = (b0[3:0] == 4'h5) ? 4'd0 : f[10:7];
            e_frame = (b0[3:0] == 4'h5) ? f[10:0] : 11'd0;
          end
        end else if (len < 3) lmark[last ? st + len - 1 : st + len] = 1;
        else lmark[st + 2] = 1;
      end
    end
    for (int i = 0; i < 64; i++) if (lmark[i]) m_len++;
    m_cnt = (m_cnt + m_crc > 255) ? 255 : m_cnt + m_crc;
  endtask

  task automatic push(input logic [7:0] d, input bit s);
    b_data.push_back(d);
    b_sop.push_back(s);
  endtask

  task automatic add_token(input logic [3:0] p, input logic [10:0] d, input bit corrupt);
    logic [15:0] f;
    f = {crc5_tx(d), d};
    if (corrupt) f = f ^ (16'd1 << $urandom_range(15, 0));
    push({~p, p}, 1);
    push(f[7:0], 0);
    push(f[15:8], 0);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit s, input bit e);
    int guard;
    guard = 0;
    while (!(rx_ready_a && rx_ready_b) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) chk("rx_ready_timeout", 0, 1);
    rx_valid = 1; rx_data = d; rx_sop = s; rx_eop = e;
    @(posedge clk); #1;
    rx_valid = 0; rx_sop = 0; rx_eop = 0;
  endtask

  task automatic check_hold();
    chk("rx_ready_a", rx_ready_a, !m_tok_a);
    chk("rx_ready_b", rx_ready_b, !m_tok_b);
    if (m_tok_a) begin
      chk("pid_a", tok_pid_a, e_pid);    chk("addr_a", tok_addr_a, e_addr);
      chk("endp_a", tok_endp_a, e_endp); chk("frame_a", tok_frame_a, e_frame);
    end
    if (m_tok_b) begin
      chk("pid_b", tok_pid_b, e_pid);    chk("addr_b", tok_addr_b, e_addr);
      chk("endp_b", tok_endp_b, e_endp); chk("frame_b", tok_frame_b, e_frame);
    end
  endtask

  task automatic run_burst(input int hold);
    int s_crc_a, s_pid_a, s_len_a, s_crc_b, s_pid_b, s_len_b;
    model_burst();
    s_crc_a = n_crc_a; s_pid_a = n_pid_a; s_len_a = n_len_a;
    s_crc_b = n_crc_b; s_pid_b = n_pid_b; s_len_b = n_len_b;
    for (int i = 0; i < b_data.size(); i++)
      send_byte(b_data[i], b_sop[i], i == b_data.size() - 1);
    chk("tok_valid_a", tok_valid_a, m_tok_a);
    chk("tok_valid_b", tok_valid_b, m_tok_b);
    if (m_tok_a || m_tok_b) begin
      for (int k = 0; k < hold; k++) begin
        check_hold();
        @(posedge clk); #1;
      end
      check_hold();
      tok_ready = 1;
      @(posedge clk); #1;
      tok_ready = 0;
      chk("released_a", {tok_valid_a, rx_ready_a}, 2'b01);
      chk("released_b", {tok_valid_b, rx_ready_b}, 2'b01);
    end
    @(posedge clk); #1;
    chk("crc_pulses_a", n_crc_a - s_crc_a, m_crc);
    chk("pid_pulses_a", n_pid_a - s_pid_a, m_pid);
    chk("len_pulses_a", n_len_a - s_len_a, m_len);
    chk("crc_pulses_b", n_crc_b - s_crc_b, m_crc);
    chk("pid_pulses_b", n_pid_b - s_pid_b, m_pid);
    chk("len_pulses_b", n_len_b - s_len_b, m_len);
    chk("cnt_a", cnt_a, m_cnt);
    chk("cnt_b", cnt_b, m_cnt);
  endtask

  task automatic new_burst();
    b_data.delete();
    b_sop.delete();
  endtask

  task automatic gen_random();
    int kind;
    logic [3:0]  p;
    logic [10:0] d;
    logic [7:0]  b;
    new_burst();
    if ($urandom_range(0, 7) == 0) push(8'($urandom_range(0, 255)), 0);
    repeat ($urandom_range(1, 2)) begin
      kind = $urandom_range(0, 9);
      p = pids[$urandom_range(0, 3)];
      d = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 1) == 1) d[6:0] = self_addr;
      if (kind <= 5) add_token(p, d, kind == 5);
      else if (kind <= 7) begin
        p = 4'($urandom_range(0, 15));
        b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : {~p, p};
        push(b, 1);
        repeat ($urandom_range(0, 3)) push(8'($urandom_range(0, 255)), 0);
      end else begin
        add_token(p, d, 0);
        if (kind == 8) begin
          repeat ($urandom_range(1, 2)) begin
            void'(b_data.pop_back());
            void'(b_sop.pop_back());
          end
        end else push(8'($urandom_range(0, 255)), 0);
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; self_addr = 7'd0; rx_valid = 0; rx_data = '0; rx_sop = 0; rx_eop = 0; tok_ready = 0;
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_a", {rx_ready_a, tok_valid_a, crc5_err_a, pid_err_a, len_err_a}, 5'b10000);
    chk("reset_b", {rx_ready_b, tok_valid_b, crc5_err_b, pid_err_b, len_err_b}, 5'b10000);
    chk("reset_cnt", cnt_a, 0);

    // SETUP addr 0 endp 0, held three cycles
    new_burst(); push(8'h2D, 1); push(8'h00, 0); push(8'h10, 0);
    run_burst(3);

    // CRC failure, then saturation
    new_burst(); push(8'h2D, 1); push(8'h00, 0); push(8'h11, 0);
    run_burst(0);
    chk("cnt_first", cnt_a, 1);
    repeat (299) run_burst(0);
    chk("cnt_saturated", cnt_a, 255);

    // PID check failure, then an ACK handshake packet
    new_burst(); push(8'h2E, 1); push(8'h00, 0); push(8'h10, 0);
    run_burst(0);
    new_burst(); push(8'hD2, 1);
    run_burst(0);

    // address filtering: dut_a drops, dut_b delivers
    self_addr = 7'd5;
    new_burst(); push(8'h2D, 1); push(8'h00, 0); push(8'h10, 0);
    run_burst(1);

    // framing errors
    self_addr = 7'd0;
    new_burst(); push(8'h2D, 1); push(8'h00, 0); push(8'h10, 0); push(8'h55, 0);
    run_burst(0);
    new_burst(); push(8'h2D, 1); push(8'h00, 0);
    run_burst(0);
    new_burst(); push(8'h2D, 1); push(8'h2D, 1); push(8'h00, 0); push(8'h10, 0);
    run_burst(1);

    // SOF frame 0x5A3
    new_burst(); add_token(4'h5, 11'h5A3, 0);
    run_burst(1);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) self_addr = 7'($urandom_range(0, 127));
      gen_random();
      run_burst($urandom_range(0, 2));
    end

    // reset in the middle of a packet
    send_byte(8'h2D, 1, 0);
    send_byte(8'h00, 0, 0);
    rst = 1;
    #1;
    chk("midrst_a", {rx_ready_a, tok_valid_a, crc5_err_a, pid_err_a, len_err_a}, 5'b10000);
    chk("midrst_cnt_a", cnt_a, 0);
    chk("midrst_cnt_b", cnt_b, 0);
    @(posedge clk); #1;
    rst = 0;
    m_cnt = 0;
    self_addr = 7'd0;
    new_burst(); push(8'h2D, 1); push(8'h00, 0); push(8'h10, 0);
    run_burst(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
